// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner
// Description : Multiplexed common-cathode 7-segment driver with per-digit
//               decimal points, leading-zero blanking, PWM dimming and
//               frame-synchronous double-buffered display updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_TICKS = 100_000,
    parameter int PWM_BITS      = 4
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic [PWM_BITS-1:0]   brightness,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit,
    output logic                  frame_done
);

    localparam int c_SLOT_W = $clog2(REFRESH_TICKS);
    localparam int c_IDX_W  = $clog2(DIGITS);
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(REFRESH_TICKS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

    logic [c_SLOT_W-1:0]  r_slot_cnt;
    logic [c_IDX_W-1:0]   r_scan_idx;
    logic [PWM_BITS-1:0]  r_phase;
    logic [4*DIGITS-1:0]  r_disp_val;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [4*DIGITS-1:0]  r_shadow_val;
    logic [DIGITS-1:0]    r_shadow_dp;
    logic                 r_pending;

    logic                 w_slot_end;
    logic                 w_frame_end;
    logic [3:0]           w_nibble;
    logic [DIGITS-1:0]    w_upper_zero;
    logic                 w_blank;
    logic                 w_pwm_on;
    logic [DIGITS-1:0]    w_anodes;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    assign w_slot_end  = (r_slot_cnt == c_SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_scan_idx == c_IDX_LAST);

    // w_upper_zero[i]: nibbles i..DIGITS-1 of the display register are all zero
    always_comb begin
        logic zero_run;
        zero_run     = 1'b1;
        w_upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run        = zero_run && (r_disp_val[4*i +: 4] == 4'h0);
            w_upper_zero[i] = zero_run;
        end
    end

    always_comb begin
        w_nibble = r_disp_val[{r_scan_idx, 2'b00} +: 4];
        w_blank  = lz_blank && (r_scan_idx != '0) && w_upper_zero[r_scan_idx];
        w_pwm_on = (r_phase < brightness) || (&brightness);
        w_anodes = ~(DIGITS'(1) << r_scan_idx);
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_slot_cnt   <= '0;
            r_scan_idx   <= '0;
            r_phase      <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
            seg          <= '0;
            dp_out       <= 1'b0;
            digit        <= '1;
            frame_done   <= 1'b0;
        end else begin
            r_phase <= r_phase + 1'b1;

            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            // A load on the boundary bypasses the shadow so it is not lost
            if (w_frame_end) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_disp_val <= value;
                    r_disp_dp  <= dp;
                end else if (r_pending) begin
                    r_disp_val <= r_shadow_val;
                    r_disp_dp  <= r_shadow_dp;
                end
            end else if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp;
                r_pending    <= 1'b1;
            end

            frame_done <= w_frame_end;

            if (w_pwm_on) begin
                digit  <= w_anodes;
                seg    <= w_blank ? 7'h00 : f_decode(w_nibble);
                dp_out <= r_disp_dp[r_scan_idx];
            end else begin
                digit  <= '1;
                seg    <= '0;
                dp_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scanner
// Description : Scoreboard bench for seven_seg_scanner (4 digits, 4-tick slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int c_D = 4;
    localparam int c_R = 4;
    localparam int c_P = 4;
    localparam int c_FRAME = c_D * c_R;

    logic             clk_100MHz;
    logic             reset;
    logic [15:0]      value;
    logic [3:0]       dp;
    logic             load;
    logic [3:0]       brightness;
    logic             lz_blank;
    logic [6:0]       seg;
    logic             dp_out;
    logic [3:0]       digit;
    logic             frame_done;

    seven_seg_scanner #(
        .DIGITS        (c_D),
        .REFRESH_TICKS (c_R),
        .PWM_BITS      (c_P)
    ) u_dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .brightness (brightness),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .dp_out     (dp_out),
        .digit      (digit),
        .frame_done (frame_done)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
        int         cyc;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: time since reset release plus the display buffers
    int          t = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_shadow_dp = '0;
    bit          m_pend = 0;
    logic [3:0]  br_v = 4'hF;
    logic        lz_v = 1'b0;

    task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic [3:0] d);
        exp_t e;
        int   idx, phase;
        bit   bnd, on, blank;
        @(negedge clk_100MHz);
        #1;
        reset = rst; load = ld; value = v; dp = d;
        brightness = br_v; lz_blank = lz_v;
        cyc++;
        e.cyc = cyc;
        if (rst) begin
            e.seg = 7'h00; e.dp = 1'b0; e.dig = 4'hF; e.fd = 1'b0;
            t = 0; m_disp = '0; m_disp_dp = '0; m_shadow = '0; m_shadow_dp = '0; m_pend = 0;
        end else begin
            idx   = (t / c_R) % c_D;
            phase = t % (1 << c_P);
            bnd   = (t % c_FRAME) == c_FRAME - 1;
            on    = (phase < int'(br_v)) || (br_v == 4'hF);
            blank = 0;
            if (lz_v && idx > 0) begin
                blank = 1;
                for (int j = idx; j < c_D; j++)
                    if (((m_disp >> (4 * j)) & 16'hF) != 0) blank = 0;
            end
            e.fd = bnd;
            if (on) begin
                e.dig = 4'hF & ~(4'(1) << idx);
                e.seg = blank ? 7'h00 : seg_tbl[(m_disp >> (4 * idx)) & 16'hF];
                e.dp  = m_disp_dp[idx];
            end else begin
                e.dig = 4'hF; e.seg = 7'h00; e.dp = 1'b0;
            end
            if (bnd) begin
                if (ld) begin m_disp = v; m_disp_dp = d; end
                else if (m_pend) begin m_disp = m_shadow; m_disp_dp = m_shadow_dp; end
                m_pend = 0;
            end else if (ld) begin
                m_shadow = v; m_shadow_dp = d; m_pend = 1;
            end
            t++;
        end
        q_exp.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        step(1'b0, 1'b1, v, d);
    endtask

    always @(negedge clk_100MHz) begin
        exp_t e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (seg !== e.seg || dp_out !== e.dp || digit !== e.dig || frame_done !== e.fd) begin
                n_errors++;
                $display("FAIL outputs cycle %0d: got seg=%h dp=%b digit=%b fd=%b, want seg=%h dp=%b digit=%b fd=%b",
                         e.cyc, seg, dp_out, digit, frame_done, e.seg, e.dp, e.dig, e.fd);
            end
        end
    end

    initial begin
        logic [15:0] rv;
        reset = 1'b1; load = 1'b0; value = '0; dp = '0; brightness = 4'hF; lz_blank = 1'b0;

        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(4);

        do_load(16'h12AF, 4'b0100);
        idle(40);

        do_load(16'h1111, 4'b0000);
        idle(20);
        while ((t % c_FRAME) != c_R + 1) idle(1);
        do_load(16'h2222, 4'b0000);
        idle(24);

        while ((t % c_FRAME) != c_FRAME - 1) idle(1);
        do_load(16'h3C5A, 4'b1001);
        idle(8);

        lz_v = 1'b1;
        do_load(16'h0005, 4'b0010);
        idle(34);
        do_load(16'h0000, 4'b0000);
        idle(34);
        do_load(16'h0F05, 4'b1000);
        idle(34);
        lz_v = 1'b0;

        br_v = 4'h0; idle(64);
        br_v = 4'h4; idle(64);
        br_v = 4'hF; idle(20);

        while ((t % c_FRAME) != 1) idle(1);
        do_load(16'hABCD, 4'b1111);
        while ((t % c_FRAME) != 2 * c_R + 1) idle(1);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        idle(36);

        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 4; k++)
                rv[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) br_v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) lz_v = ~lz_v;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0), rv, 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk_100MHz);
        #2;
        n_checks++;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
